// File: rtl/ixu_div_ctrl.sv
// ixu_div_ctrl: issue-side sequencer for the ixu_div start/busy/done divider.
// Accepts one divide/remainder op, registers its operands, pulses start and
// waits for completion. It then holds the tagged result on the writeback port
// until that result is consumed.
// Optional feature macro: IXU_DIV_RESULT_CACHE_EN adds a one-entry result
// cache. Repeated identical ops are answered without starting the divider.
module ixu_div_ctrl #(
  parameter int TAG_W = 6
) (
  input  logic             core_clock_i,
  input  logic             core_reset_n_i,
  input  logic             core_flush_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic             issue_opcode_i,
  input  logic             issue_unsigned_i,
  input  logic [31:0]      issue_a_i,
  input  logic [31:0]      issue_b_i,
  input  logic [TAG_W-1:0] issue_tag_i,
  output logic             div_start_o,
  output logic             div_opcode_o,
  output logic             div_unsigned_o,
  output logic [31:0]      div_a_o,
  output logic [31:0]      div_b_o,
  input  logic             div_busy_i,
  input  logic             div_done_i,
  input  logic             div_dbz_i,
  input  logic             div_overflow_i,
  input  logic [31:0]      div_res_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [31:0]      wb_data_o,
  output logic             wb_dbz_o,
  output logic             wb_overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;

  // Captured micro-op; these feed the divider directly.
  logic             op_q, op_d;
  logic             uns_q, uns_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Writeback result registers.
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_dbz_q, wb_dbz_d;
  logic             wb_ovf_q, wb_ovf_d;

  // Event strobes; flush masks every event that would change state.
  logic             issue_fire;
  logic             div_complete;
  logic             wb_fire;

  // Cache view, constant in the build without the cache.
  logic             cache_hit;
  logic [31:0]      cache_res;
  logic             cache_dbz;
  logic             cache_ovf;

  assign issue_fire   = (state_q == ST_IDLE) & issue_valid_i & ~core_flush_i;
  // A done seen while busy is still high belongs to an aborted op.
  assign div_complete = (state_q == ST_WAIT) & div_done_i & ~div_busy_i & ~core_flush_i;
  assign wb_fire      = (state_q == ST_RESP) & wb_ready_i;

`ifdef IXU_DIV_RESULT_CACHE_EN
  logic        cache_vld_q, cache_vld_d;
  logic [31:0] cache_a_q, cache_a_d;
  logic [31:0] cache_b_q, cache_b_d;
  logic        cache_uns_q, cache_uns_d;
  logic        cache_op_q, cache_op_d;
  logic [31:0] cache_res_q, cache_res_d;
  logic        cache_dbz_q, cache_dbz_d;
  logic        cache_ovf_q, cache_ovf_d;

  // Lookup uses the live issue inputs so a hit can skip START entirely.
  assign cache_hit = cache_vld_q
                   & (cache_a_q   == issue_a_i)
                   & (cache_b_q   == issue_b_i)
                   & (cache_uns_q == issue_unsigned_i)
                   & (cache_op_q  == issue_opcode_i);
  assign cache_res = cache_res_q;
  assign cache_dbz = cache_dbz_q;
  assign cache_ovf = cache_ovf_q;

  // Refill the entry on every surviving divider completion; flush leaves it intact.
  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_a_d   = cache_a_q;
    cache_b_d   = cache_b_q;
    cache_uns_d = cache_uns_q;
    cache_op_d  = cache_op_q;
    cache_res_d = cache_res_q;
    cache_dbz_d = cache_dbz_q;
    cache_ovf_d = cache_ovf_q;
    if (div_complete) begin
      cache_vld_d = 1'b1;
      cache_a_d   = a_q;
      cache_b_d   = b_q;
      cache_uns_d = uns_q;
      cache_op_d  = op_q;
      cache_res_d = div_res_i;
      cache_dbz_d = div_dbz_i;
      cache_ovf_d = div_overflow_i;
    end
  end

  // Cache storage; only reset invalidates it.
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      cache_vld_q <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_uns_q <= 1'b0;
      cache_op_q  <= 1'b0;
      cache_res_q <= '0;
      cache_dbz_q <= 1'b0;
      cache_ovf_q <= 1'b0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_a_q   <= cache_a_d;
      cache_b_q   <= cache_b_d;
      cache_uns_q <= cache_uns_d;
      cache_op_q  <= cache_op_d;
      cache_res_q <= cache_res_d;
      cache_dbz_q <= cache_dbz_d;
      cache_ovf_q <= cache_ovf_d;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
  assign cache_dbz = 1'b0;
  assign cache_ovf = 1'b0;
`endif

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (issue_fire) state_d = cache_hit ? ST_RESP : ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (div_complete) state_d = ST_RESP;
      ST_RESP:  if (wb_fire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (core_flush_i) state_d = ST_IDLE;
  end

  // Operand capture on acceptance; held unchanged through START and WAIT.
  always_comb begin
    op_d  = op_q;
    uns_d = uns_q;
    a_d   = a_q;
    b_d   = b_q;
    tag_d = tag_q;
    if (issue_fire) begin
      op_d  = issue_opcode_i;
      uns_d = issue_unsigned_i;
      a_d   = issue_a_i;
      b_d   = issue_b_i;
      tag_d = issue_tag_i;
    end
  end

  // Writeback load from either the divider or the cache.
  always_comb begin
    wb_data_d = wb_data_q;
    wb_dbz_d  = wb_dbz_q;
    wb_ovf_d  = wb_ovf_q;
    if (div_complete) begin
      wb_data_d = div_res_i;
      wb_dbz_d  = div_dbz_i;
      wb_ovf_d  = div_overflow_i;
    end else if (issue_fire && cache_hit) begin
      wb_data_d = cache_res;
      wb_dbz_d  = cache_dbz;
      wb_ovf_d  = cache_ovf;
    end
  end

  // State, capture and writeback registers.
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_q   <= ST_IDLE;
      op_q      <= 1'b0;
      uns_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      wb_data_q <= '0;
      wb_dbz_q  <= 1'b0;
      wb_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      uns_q     <= uns_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      wb_data_q <= wb_data_d;
      wb_dbz_q  <= wb_dbz_d;
      wb_ovf_q  <= wb_ovf_d;
    end
  end

  // Outputs decode from state and registers only; ready never sees wb_ready_i.
  assign issue_ready_o  = (state_q == ST_IDLE);
  assign div_start_o    = (state_q == ST_START);
  assign div_opcode_o   = op_q;
  assign div_unsigned_o = uns_q;
  assign div_a_o        = a_q;
  assign div_b_o        = b_q;
  assign wb_valid_o     = (state_q == ST_RESP);
  assign wb_tag_o       = tag_q;
  assign wb_data_o      = wb_data_q;
  assign wb_dbz_o       = wb_dbz_q;
  assign wb_overflow_o  = wb_ovf_q;

endmodule

// File: tb/tb_ixu_div_ctrl.sv
// Bench for ixu_div_ctrl: divider stub, table vectors, corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_ixu_div_ctrl;
  localparam int TAG_W = 6;
`ifdef IXU_DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 35;
`endif

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic issue_valid = 1'b0, issue_ready, issue_op = 1'b0, issue_uns = 1'b0;
  logic [31:0] issue_a = '0, issue_b = '0;
  logic [TAG_W-1:0] issue_tag = '0;
  logic div_start, div_op, div_uns, div_busy, div_done, div_dbz, div_ovf;
  logic [31:0] div_a, div_b, div_res;
  logic wb_valid, wb_ready = 1'b0, wb_dbz, wb_ovf;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0] wb_data;
  logic force_done = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ixu_div_ctrl #(.TAG_W(TAG_W)) dut (
    .core_clock_i(clk), .core_reset_n_i(rst_n), .core_flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_opcode_i(issue_op), .issue_unsigned_i(issue_uns),
    .issue_a_i(issue_a), .issue_b_i(issue_b), .issue_tag_i(issue_tag),
    .div_start_o(div_start), .div_opcode_o(div_op), .div_unsigned_o(div_uns),
    .div_a_o(div_a), .div_b_o(div_b),
    .div_busy_i(div_busy), .div_done_i(div_done), .div_dbz_i(div_dbz),
    .div_overflow_i(div_ovf), .div_res_i(div_res),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_tag_o(wb_tag),
    .wb_data_o(wb_data), .wb_dbz_o(wb_dbz), .wb_overflow_o(wb_ovf)
  );

  // RISC-V divide semantics; returns {overflow, dbz, result}.
  function automatic logic [33:0] ref_div(input logic op, input logic uns,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic dbz, ovf;
    dbz = (b == 32'd0);
    ovf = !uns && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (dbz) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (ovf) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (uns) begin
      q = a / b; r = a % b;
    end else begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end
    return {ovf, dbz, op ? r : q};
  endfunction

  // Divider stub: special cases finish one cycle after start, others after 32 busy cycles.
  logic [33:0] dm_r;
  logic dm_busy, dm_done, dm_dbz, dm_ovf;
  logic [31:0] dm_res;
  int dm_cnt;
  assign dm_r = ref_div(div_op, div_uns, div_a, div_b);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_busy <= 1'b0; dm_done <= 1'b0; dm_cnt <= 0;
      dm_res <= '0; dm_dbz <= 1'b0; dm_ovf <= 1'b0;
    end else if (flush) begin
      dm_busy <= 1'b0; dm_done <= 1'b0; dm_cnt <= 0;
    end else if (div_start) begin
      dm_res <= dm_r[31:0]; dm_dbz <= dm_r[32]; dm_ovf <= dm_r[33];
      if (dm_r[32] || dm_r[33]) begin
        dm_busy <= 1'b0; dm_done <= 1'b1; dm_cnt <= 0;
      end else begin
        dm_busy <= 1'b1; dm_done <= 1'b0; dm_cnt <= 32;
      end
    end else if (dm_cnt > 0) begin
      dm_cnt <= dm_cnt - 1;
      if (dm_cnt == 1) begin
        dm_busy <= 1'b0; dm_done <= 1'b1;
      end
    end else begin
      dm_done <= 1'b0;
    end
  end
  assign div_busy = dm_busy;
  assign div_done = dm_done | force_done;
  assign div_dbz  = dm_dbz;
  assign div_ovf  = dm_ovf;
  assign div_res  = dm_res;

  // Reference model of the result cache: the last op that finished unflushed.
  bit mdl_vld = 1'b0, mdl_op, mdl_uns;
  logic [31:0] mdl_a, mdl_b;

  function automatic int exp_latency(input logic op, input logic uns,
                                     input logic [31:0] a, input logic [31:0] b);
    logic [33:0] r;
    r = ref_div(op, uns, a, b);
`ifdef IXU_DIV_RESULT_CACHE_EN
    if (mdl_vld && mdl_op == op && mdl_uns == uns && mdl_a == a && mdl_b == b) return 1;
`endif
    return (r[32] || r[33]) ? 3 : 35;
  endfunction

  task automatic mdl_set(input logic op, input logic uns, input logic [31:0] a, input logic [31:0] b);
    mdl_vld = 1'b1; mdl_op = op; mdl_uns = uns; mdl_a = a; mdl_b = b;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op and return the cycle at which wb_valid rises (cycle 0 = accept).
  task automatic issue_and_wait(input logic op, input logic uns, input logic [31:0] a,
                                input logic [31:0] b, input logic [TAG_W-1:0] tag,
                                output int lat, output int starts);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!issue_ready && guard < 100) begin
      @(negedge clk); guard++;
    end
    chk("issue_ready", 32'(issue_ready), 32'd1);
    issue_valid = 1'b1; issue_op = op; issue_uns = uns;
    issue_a = a; issue_b = b; issue_tag = tag;
    @(negedge clk);
    issue_valid = 1'b0;
    lat = 1; starts = 0;
    while (!wb_valid && lat < 100) begin
      if (div_start) starts++;
      @(negedge clk); lat++;
    end
    if (div_start) starts++;
  endtask

  // Hold the response for dly cycles, then accept it.
  task automatic consume(input int dly);
    logic [31:0] d0;
    logic [TAG_W-1:0] t0;
    bit stable;
    d0 = wb_data; t0 = wb_tag; stable = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (!wb_valid || wb_data !== d0 || wb_tag !== t0 || issue_ready) stable = 1'b0;
    end
    if (dly > 0) chk("resp_hold_stable", 32'(stable), 32'd1);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("consume_valid_low", 32'(wb_valid), 32'd0);
    chk("consume_idle", 32'(issue_ready), 32'd1);
  endtask

  task automatic run_check(input logic op, input logic uns, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag, input int dly,
                           input logic [31:0] e_data, input logic e_dbz, input logic e_ovf,
                           input int e_lat, input string name);
    int lat, starts;
    issue_and_wait(op, uns, a, b, tag, lat, starts);
    chk({name, "_latency"}, 32'(lat), 32'(e_lat));
    if (lat < 100) begin
      chk({name, "_data"}, wb_data, e_data);
      chk({name, "_dbz"}, 32'(wb_dbz), 32'(e_dbz));
      chk({name, "_ovf"}, 32'(wb_ovf), 32'(e_ovf));
      chk({name, "_tag"}, 32'(wb_tag), 32'(tag));
      chk({name, "_starts"}, 32'(starts), (e_lat == 1) ? 32'd0 : 32'd1);
      consume(dly);
    end
    mdl_set(op, uns, a, b);
  endtask

  // Issue an op and flush it at cycle fcyc; it must never produce a response.
  task automatic flush_op(input logic op, input logic uns, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input int fcyc, input string name);
    int cyc;
    bit seen;
    @(negedge clk);
    issue_valid = 1'b1; issue_op = op; issue_uns = uns;
    issue_a = a; issue_b = b; issue_tag = tag;
    @(negedge clk);
    issue_valid = 1'b0;
    cyc = 1; seen = 1'b0;
    while (cyc < fcyc) begin
      if (wb_valid) seen = 1'b1;
      @(negedge clk); cyc++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk({name, "_idle"}, 32'(issue_ready), 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (wb_valid || div_start) seen = 1'b1;
      @(negedge clk);
    end
    chk({name, "_no_response"}, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic op; logic uns; logic [31:0] a; logic [31:0] b; logic [TAG_W-1:0] tag;
    int dly; logic [31:0] data; logic dbz; logic ovf; int lat;
  } vec_t;
  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, starts;
    logic [33:0] r;
    logic rop, runs;
    logic [31:0] ra, rb;
    int sel;

    vt[0] = '{1'b0, 1'b1, 32'd100,         32'd7,          6'd5,  10, 32'd14,         1'b0, 1'b0, 35};
    vt[1] = '{1'b1, 1'b0, 32'hFFFF_FFF9,   32'd2,          6'd1,  0,  32'hFFFF_FFFF,  1'b0, 1'b0, 35};
    vt[2] = '{1'b0, 1'b0, 32'h8000_0000,   32'hFFFF_FFFF,  6'd2,  1,  32'h8000_0000,  1'b0, 1'b1, 3};
    vt[3] = '{1'b0, 1'b1, 32'd1234,        32'd0,          6'd3,  2,  32'hFFFF_FFFF,  1'b1, 1'b0, 3};
    vt[4] = '{1'b1, 1'b1, 32'd100,         32'd7,          6'd4,  0,  32'd2,          1'b0, 1'b0, 35};
    vt[5] = '{1'b0, 1'b0, 32'hFFFF_FF9C,   32'd7,          6'd6,  3,  32'hFFFF_FFF2,  1'b0, 1'b0, 35};
    vt[6] = '{1'b1, 1'b0, 32'h1234_5678,   32'd0,          6'd7,  0,  32'h1234_5678,  1'b1, 1'b0, 3};
    vt[7] = '{1'b0, 1'b0, 32'h8000_0000,   32'd1,          6'd63, 1,  32'h8000_0000,  1'b0, 1'b0, 35};

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_tag", 32'(wb_tag), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_flags", 32'({wb_dbz, wb_ovf, div_op, div_uns}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(issue_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      run_check(vt[i].op, vt[i].uns, vt[i].a, vt[i].b, vt[i].tag, vt[i].dly,
                vt[i].data, vt[i].dbz, vt[i].ovf, vt[i].lat, $sformatf("vec%0d", i));

    // Done held high everywhere: ignored in IDLE/START and while busy.
    force_done = 1'b1;
    run_check(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 6'd11, 0, 32'h5555_5555, 1'b0, 1'b0, 35, "stale_done");
    force_done = 1'b0;

    // Flush in IDLE with a valid op present: nothing is accepted.
    @(negedge clk);
    flush = 1'b1; issue_valid = 1'b1; issue_op = 1'b0; issue_uns = 1'b1;
    issue_a = 32'd9; issue_b = 32'd4;
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0;
    chk("idle_flush_ready", 32'(issue_ready), 32'd1);
    chk("idle_flush_no_start", 32'(div_start), 32'd0);

    // Flush mid-divide, then a fresh op and its repeat.
    flush_op(1'b0, 1'b1, 32'd500, 32'd3, 6'd8, 20, "flush20");
    run_check(1'b0, 1'b1, 32'd1000, 32'd9, 6'd9, 0, 32'd111, 1'b0, 1'b0, 35, "after_flush");
    run_check(1'b0, 1'b1, 32'd1000, 32'd9, 6'd10, 0, 32'd111, 1'b0, 1'b0, HIT_LAT, "repeat_op");

    // Flush on the completion cycle kills the result and keeps it out of the cache.
    flush_op(1'b1, 1'b1, 32'd77, 32'd5, 6'd12, 34, "flush34");
    run_check(1'b1, 1'b1, 32'd77, 32'd5, 6'd13, 0, 32'd2, 1'b0, 1'b0, 35, "flushed_not_cached");

    // Flush while holding a response.
    issue_and_wait(1'b0, 1'b0, 32'd50, 32'hFFFF_FFFB, 6'd14, lat, starts);
    chk("resp_flush_lat", 32'(lat), 32'(exp_latency(1'b0, 1'b0, 32'd50, 32'hFFFF_FFFB)));
    chk("resp_flush_data", wb_data, 32'hFFFF_FFF6);
    mdl_set(1'b0, 1'b0, 32'd50, 32'hFFFF_FFFB);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("resp_flush_valid_low", 32'(wb_valid), 32'd0);
    chk("resp_flush_idle", 32'(issue_ready), 32'd1);

    // Asynchronous reset while holding a response; the cache is cleared too.
    issue_and_wait(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h10, 6'd20, lat, starts);
    chk("areset_pre_data", wb_data, 32'h0DEA_DBEE);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(wb_valid), 32'd0);
    chk("areset_data", wb_data, 32'd0);
    chk("areset_tag", 32'(wb_tag), 32'd0);
    chk("areset_div_a", div_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_vld = 1'b0;
    run_check(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h10, 6'd21, 0, 32'h0DEA_DBEE, 1'b0, 1'b0, 35, "after_areset");

    // Randomized ops against the reference model.
    rop = 1'b0; runs = 1'b1; ra = 32'd1; rb = 32'd1;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 7));
      if (sel > 1) begin
        rop = 1'($urandom_range(0, 1));
        runs = 1'($urandom_range(0, 1));
        ra = $urandom;
        rb = $urandom;
        if (sel == 2) rb = 32'd0;
        if (sel == 3) begin
          runs = 1'b0; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
        end
        if (sel == 4) rb = 32'($urandom_range(1, 15));
      end
      r = ref_div(rop, runs, ra, rb);
      run_check(rop, runs, ra, rb, TAG_W'($urandom), int'($urandom_range(0, 3)),
                r[31:0], r[32], r[33], exp_latency(rop, runs, ra, rb), $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
